busca_instrucao: RTL and testbench
==================================

# busca_instrucao

Instruction fetch unit for the 16-bit MIPS datapath. It takes the current program-counter address and runs a request/acknowledge transaction with instruction memory. It latches the returned 16-bit instruction, pre-decodes its fields and presents it to the decode stage with a valid/consume handshake. It drives `stall` back to the program counter, and provides flush, misalignment-fault and timeout-fault handling.

## Interface
- `TIMEOUT`, 16: maximum cycles `mem_req` may stay high without `mem_ack` before a fault.
- `clock`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `pc_addr`  in  16  fetch address from the program counter.
- `fetch_en`  in  1  permission to launch a new fetch.
- `flush`  in  1  discard the outstanding or held instruction (branch/jump/jr taken).
- `mem_req`  out  1  request to instruction memory.
- `mem_addr`  out  16  request address. Stable while `mem_req`=1.
- `mem_ack`  in  1  memory completion. `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  16  instruction word from memory.
- `instr_valid`  out  1  `instr` and the decoded fields are valid.
- `consume`  in  1  decode stage accepts the instruction.
- `instr`  out  16  latched instruction.
- `instr_pc`  out  16  address the instruction was fetched from.
- `opcode`  out  3  `instr[15:13]`.
- `target_jump`  out  13  `instr[12:0]`.
- `imm_ext`  out  16  `instr[6:0]` sign-extended to 16 bits.
- `stall`  out  1  the program counter must hold its value.
- `fault`  out  1  sticky error: misaligned address or memory timeout.

## Operation
- **States:**
  - IDLE: no request outstanding, `instr_valid`=0.
  - REQ: request outstanding.
  - HOLD: instruction held, `instr_valid`=1.
  - DISCARD: a flushed request is still awaiting its ack.
- **IDLE**
  - `fetch_en`=1, `fault`=0, `flush`=0 and `pc_addr[0]`=0: capture `pc_addr` into `mem_addr`, go to REQ.
  - `fetch_en`=1 with `pc_addr[0]`=1: set `fault`, stay in IDLE. No request is issued.
- **REQ**
  - `mem_req`=1.
  - On `mem_ack`: latch `mem_rdata` into `instr`, copy `mem_addr` into `instr_pc`, register the decoded fields, go to HOLD.
- **HOLD**
  - `consume`=1: next state is REQ with a newly captured `pc_addr` if IDLE's launch conditions hold; otherwise IDLE. The misalignment check still applies.
  - `consume`=0: outputs hold unchanged.
- **Flush**
  - In REQ with `mem_ack` in the same cycle: the data is dropped and the next state is IDLE.
  - In REQ without `mem_ack`: go to DISCARD. `mem_req` stays high, because a request cannot be withdrawn. On `mem_ack` the data is dropped and the next state is IDLE.
  - In HOLD: `instr_valid` clears and the next state is IDLE. Flush has priority over a simultaneous `consume`; that instruction counts as not delivered.
  - In IDLE: no effect. It also blocks a launch in that cycle.
- **Timeout**
  - An internal counter resets to 0 on entry to REQ or DISCARD and increments each cycle without `mem_ack`.
  - If the counter reaches `TIMEOUT`-1 with no ack: set `fault`, drop `mem_req`, go to IDLE.
- **Fault:** `fault` is sticky until `reset`. While it is set, no new fetch is launched and `stall`=1.
- **`stall`:** equals 0 only in a HOLD cycle with `consume`=1 and `flush`=0; 1 otherwise.
- **Flush and `stall`:** during a flush cycle the program counter advances on its own redirect path, independent of `stall`.

## Timing
- **Reset values:** state IDLE. All outputs 0 (`mem_req`, `mem_addr`, `instr_valid`, `instr`, `instr_pc`, `opcode`, `target_jump`, `imm_ext`, `fault`), except `stall`=1. The timeout counter is 0.
- **Reset mid-transaction:** asserting `reset` drops `mem_req` immediately (asynchronous). A late `mem_ack` after reset release is ignored in IDLE.
- **Latency:**
  - `fetch_en` sampled in IDLE → `mem_req` high the next cycle.
  - `mem_ack` → `instr_valid` high the next cycle.
  - Best case, launch to valid: 2 cycles with a zero-wait memory (ack in the first REQ cycle).
- **Back-to-back:** a `consume` cycle in HOLD → `mem_req` high the next cycle. With a zero-wait memory, throughput is one instruction every 2 cycles.
- **Address stability:** `mem_addr` changes only on entry to REQ.
- **Held outputs:** `instr`, `instr_pc` and the decoded fields change only on the HOLD-entry edge or on reset.
- **Ack outside a request:** `mem_ack` in IDLE or HOLD is ignored.

## Test plan
- **Basic fetch:** reset, `pc_addr`=0x0004, `fetch_en`=1, memory acks in the first REQ cycle with 0x3FFF → `mem_addr`=0x0004, `instr_valid`=1 two cycles after launch, `opcode`=1, `target_jump`=0x1FFF, `imm_ext`=0xFFFF, `instr_pc`=0x0004.
- **Stream:** `consume` held at 1, addresses 0,2,4,6, ack delay 0 → `mem_req` asserts every other cycle. `stall`=0 exactly on the four consume cycles. Instructions delivered in order.
- **Flush during wait:** ack delayed 3 cycles, `flush` asserted in cycle 1 of REQ → state DISCARD, `mem_req` held until the ack, `instr_valid` never rises, then IDLE.
- **Flush in HOLD with `consume`=1:** `instr_valid` drops the next cycle, `stall`=1 in the flush cycle, no new request that cycle.
- **Faults:**
  - `pc_addr`=0x0003 → `fault`=1 the next cycle, `mem_req` never asserts.
  - Separately, with `TIMEOUT`=4 and no ack → `fault`=1 after 4 REQ cycles, `mem_req`=0.
  - Both cases: `fault` stays set until `reset`.
- **Reset mid-REQ:** `reset` pulsed while `mem_req`=1 → `mem_req`=0 asynchronously, all outputs at reset values. An ack arriving after release is ignored.

Source files
------------

// File: rtl/busca_instrucao.sv
// Instruction fetch unit for the 16-bit MIPS datapath.
// Runs a req/ack transaction with instruction memory, holds the returned word
// with its pre-decoded fields for the decode stage, and backpressures the PC.
module busca_instrucao #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc_addr,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        instr_valid,
  input  logic        consume,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [2:0]  opcode,
  output logic [12:0] target_jump,
  output logic [15:0] imm_ext,
  output logic        stall,
  output logic        fault
);

  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_q;
  logic [15:0]   addr_q;
  logic          vld_q;
  logic [15:0]   instr_q;
  logic [15:0]   ipc_q;
  logic [2:0]    opc_q;
  logic [12:0]   tj_q;
  logic [15:0]   imm_q;
  logic          fault_q;

  // A new fetch may start only when permitted, no fault is latched, no flush
  // is redirecting the PC this cycle and the address is halfword aligned.
  logic launch_ok, misalign;
  assign launch_ok = fetch_en & ~fault_q & ~flush & ~pc_addr[0];
  assign misalign  = fetch_en & ~fault_q & pc_addr[0];

  // Fetch FSM: request tracking, timeout, fault latch and held instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      opc_q   <= '0;
      tj_q    <= '0;
      imm_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch_ok) begin
            state_q <= REQ;
            addr_q  <= pc_addr;
            req_q   <= 1'b1;
            cnt_q   <= '0;
          end else if (misalign) begin
            fault_q <= 1'b1;
          end
        end
        REQ: begin
          if (mem_ack) begin
            req_q <= 1'b0;
            if (flush) begin
              state_q <= IDLE;
            end else begin
              state_q <= HOLD;
              vld_q   <= 1'b1;
              instr_q <= mem_rdata;
              ipc_q   <= addr_q;
              opc_q   <= mem_rdata[15:13];
              tj_q    <= mem_rdata[12:0];
              imm_q   <= {{9{mem_rdata[6]}}, mem_rdata[6:0]};
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            fault_q <= 1'b1;
          end else if (flush) begin
            // The request cannot be withdrawn; wait out its ack and drop it.
            state_q <= DISCARD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DISCARD: begin
          if (mem_ack) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HOLD: begin
          if (flush) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
          end else if (consume) begin
            vld_q <= 1'b0;
            if (launch_ok) begin
              state_q <= REQ;
              addr_q  <= pc_addr;
              req_q   <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= IDLE;
              if (misalign) fault_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign instr_valid = vld_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign opcode      = opc_q;
  assign target_jump = tj_q;
  assign imm_ext     = imm_q;
  assign fault       = fault_q;
  // PC may advance only when the held instruction is being taken this cycle.
  assign stall = ~((state_q == HOLD) & consume & ~flush & ~fault_q);

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed scenarios, a transaction-level model
// checked every cycle, and hand-computed spot checks.
module tb_busca_instrucao;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc_addr = '0;
  logic        fetch_en = 1'b0, flush = 1'b0, consume = 1'b0;
  logic        mem_req, mem_ack, instr_valid, stall, fault;
  logic [15:0] mem_addr, mem_rdata, instr, instr_pc, imm_ext;
  logic [2:0]  opcode;
  logic [12:0] target_jump;

  busca_instrucao #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .pc_addr(pc_addr), .fetch_en(fetch_en),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .consume(consume),
    .instr(instr), .instr_pc(instr_pc), .opcode(opcode),
    .target_jump(target_jump), .imm_ext(imm_ext), .stall(stall), .fault(fault)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic        resp_en = 1'b0, resp_ack = 1'b0, force_ack = 1'b0, ovr_en = 1'b0;
  logic [15:0] ovr_val = '0;
  int          ack_dly = 0, wcnt = 0;

  function automatic logic [15:0] memval(input logic [15:0] a);
    return 16'h1000 + a + a + a;
  endfunction

  assign mem_ack   = resp_ack | force_ack;
  assign mem_rdata = ovr_en ? ovr_val : memval(mem_addr);

  initial forever begin
    @(posedge clock); #1;
    if (resp_en && mem_req && !reset) begin
      if (wcnt == ack_dly) begin resp_ack = 1'b1; wcnt = 0; end
      else begin resp_ack = 1'b0; wcnt++; end
    end else begin
      resp_ack = 1'b0; wcnt = 0;
    end
  end

  // ---------------- transaction-level model ----------------
  logic        m_out = 0, m_drop = 0, m_have = 0, m_fault = 0;
  int          m_wait = 0;
  logic [15:0] m_addr = '0, m_instr = '0, m_pc = '0;
  logic        s_ack = 0, s_flush = 0, s_consume = 0, s_fe = 0;
  logic [15:0] s_rdata = '0, s_pc = '0;
  logic        chk_on = 1'b0;

  function automatic logic [15:0] imm_of(input logic [15:0] w);
    return (w[6] ? 16'hFF80 : 16'h0000) | {9'd0, w[6:0]};
  endfunction

  initial begin
    logic go;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_out = 0; m_drop = 0; m_have = 0; m_fault = 0; m_wait = 0;
        m_addr = '0; m_instr = '0; m_pc = '0;
      end else begin
        go = 1'b0;
        if (m_out) begin
          if (s_ack) begin
            if (!m_drop && !s_flush) begin m_have = 1; m_instr = s_rdata; m_pc = m_addr; end
            m_out = 0; m_drop = 0;
          end else if (m_wait == TO - 1) begin
            m_fault = 1; m_out = 0; m_drop = 0;
          end else if (s_flush && !m_drop) begin
            m_drop = 1; m_wait = 0;
          end else m_wait++;
        end else if (m_have) begin
          if (s_flush) m_have = 0;
          else if (s_consume) begin m_have = 0; go = 1'b1; end
        end else go = 1'b1;
        if (go && s_fe && !m_fault) begin
          if (s_pc[0]) m_fault = 1;
          else if (!s_flush) begin m_out = 1; m_addr = s_pc; m_wait = 0; end
        end
      end
    end
  end

  // Every-cycle comparison, then snapshot the inputs the next edge will use.
  initial forever begin
    @(negedge clock);
    if (chk_on) begin
      chk("mem_req", mem_req, m_out);
      chk("mem_addr", mem_addr, m_addr);
      chk("instr_valid", instr_valid, m_have);
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_pc);
      chk("opcode", opcode, m_instr[15:13]);
      chk("target_jump", target_jump, m_instr[12:0]);
      chk("imm_ext", imm_ext, imm_of(m_instr));
      chk("fault", fault, m_fault);
      chk("stall", stall, !(m_have && consume && !flush && !m_fault));
    end
    s_ack = mem_ack; s_rdata = mem_rdata; s_flush = flush;
    s_consume = consume; s_fe = fetch_en; s_pc = pc_addr;
  end

  // ---------------- stream monitor ----------------
  logic        win = 1'b0;
  int          idx = 0;
  logic [15:0] req_vec = '0, stz_vec = '0;
  logic [15:0] got[$];

  initial forever begin
    @(negedge clock);
    if (win && idx < 16) begin
      req_vec[idx] = mem_req;
      stz_vec[idx] = !stall;
      if (instr_valid && consume && !flush) got.push_back(instr);
      idx++;
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    @(negedge clock);
    chk("post_reset_fault", fault, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_s [4];
    exp_s = '{16'h1000, 16'h1006, 16'h100C, 16'h1012};

    // Reset state
    step(); step(); reset = 1'b0; chk_on = 1'b1;
    @(negedge clock);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_stall", stall, 1'b1);
    chk("rst_instr", instr, 16'h0);
    chk("rst_fault", fault, 1'b0);

    // Basic fetch, zero-wait memory returning 0x3FFF
    resp_en = 1'b1; ack_dly = 0; ovr_en = 1'b1; ovr_val = 16'h3FFF;
    step(); pc_addr = 16'h0004; fetch_en = 1'b1;
    step(); fetch_en = 1'b0;
    @(negedge clock);
    chk("basic_req", mem_req, 1'b1);
    chk("basic_addr", mem_addr, 16'h0004);
    step();
    @(negedge clock);
    chk("basic_valid", instr_valid, 1'b1);
    chk("basic_opcode", opcode, 3'd1);
    chk("basic_tj", target_jump, 13'h1FFF);
    chk("basic_imm", imm_ext, 16'hFFFF);
    chk("basic_pc", instr_pc, 16'h0004);
    // Ack while holding is ignored
    step(); force_ack = 1'b1; ovr_val = 16'h1234;
    step(); force_ack = 1'b0;
    @(negedge clock);
    chk("hold_ack_ignored", instr, 16'h3FFF);
    step(); consume = 1'b1;
    @(negedge clock);
    chk("basic_consume_stall", stall, 1'b0);
    step(); consume = 1'b0; ovr_en = 1'b0;
    // Ack while idle is ignored
    step(); force_ack = 1'b1;
    step(); force_ack = 1'b0;
    @(negedge clock);
    chk("idle_ack_ignored", instr_valid, 1'b0);

    // Stream 0,2,4,6 with consume held high
    step(); pc_addr = 16'h0000; fetch_en = 1'b1; consume = 1'b1; win = 1'b1;
    step(); pc_addr = 16'h0002;
    step();
    step(); pc_addr = 16'h0004;
    step();
    step(); pc_addr = 16'h0006;
    step();
    step(); fetch_en = 1'b0;
    step();
    step(); consume = 1'b0; win = 1'b0;
    chk("stream_req_pattern", {16'h0, req_vec & 16'h01FF}, 32'h00AA);
    chk("stream_stall_pattern", {16'h0, stz_vec & 16'h01FF}, 32'h0154);
    chk("stream_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk($sformatf("stream_instr%0d", i), got[i], exp_s[i]);

    // Flush while waiting on a slow ack
    ack_dly = 3;
    step(); pc_addr = 16'h0008; fetch_en = 1'b1;
    step(); fetch_en = 1'b0; flush = 1'b1;
    @(negedge clock); chk("fw_req_c1", mem_req, 1'b1);
    step(); flush = 1'b0;
    @(negedge clock); chk("fw_req_discard", mem_req, 1'b1);
    step(); step();
    @(negedge clock); chk("fw_req_ackcycle", mem_req, 1'b1);
    step();
    @(negedge clock);
    chk("fw_req_done", mem_req, 1'b0);
    chk("fw_no_valid", instr_valid, 1'b0);

    // Flush in HOLD together with consume
    ack_dly = 0;
    step(); pc_addr = 16'h000A; fetch_en = 1'b1;
    step();
    step(); consume = 1'b1; flush = 1'b1;
    @(negedge clock);
    chk("fh_valid", instr_valid, 1'b1);
    chk("fh_stall", stall, 1'b1);
    step(); consume = 1'b0; flush = 1'b0; fetch_en = 1'b0;
    @(negedge clock);
    chk("fh_valid_drop", instr_valid, 1'b0);
    chk("fh_no_req", mem_req, 1'b0);

    // Misaligned address
    step(); pc_addr = 16'h0003; fetch_en = 1'b1;
    step();
    @(negedge clock);
    chk("mis_fault", fault, 1'b1);
    chk("mis_no_req", mem_req, 1'b0);
    step(); step();
    @(negedge clock);
    chk("mis_sticky", fault, 1'b1);
    chk("mis_no_req2", mem_req, 1'b0);
    fetch_en = 1'b0;
    step(); do_reset();

    // Timeout with a silent memory
    resp_en = 1'b0;
    step(); pc_addr = 16'h000C; fetch_en = 1'b1;
    step(); fetch_en = 1'b0;
    @(negedge clock); chk("to_req", mem_req, 1'b1);
    step(); step(); step();
    @(negedge clock);
    chk("to_req_last", mem_req, 1'b1);
    chk("to_nofault_yet", fault, 1'b0);
    step();
    @(negedge clock);
    chk("to_fault", fault, 1'b1);
    chk("to_req_drop", mem_req, 1'b0);
    step(); pc_addr = 16'h000E; fetch_en = 1'b1;
    step(); step();
    @(negedge clock);
    chk("to_sticky", fault, 1'b1);
    chk("to_blocked", mem_req, 1'b0);
    chk("to_stall", stall, 1'b1);
    fetch_en = 1'b0;
    step(); do_reset();

    // Reset pulsed mid-request, then a late ack
    step(); pc_addr = 16'h0010; fetch_en = 1'b1;
    step(); fetch_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_req", mem_req, 1'b0);
    chk("ar_addr", mem_addr, 16'h0);
    chk("ar_valid", instr_valid, 1'b0);
    chk("ar_stall", stall, 1'b1);
    step(); step(); reset = 1'b0; force_ack = 1'b1;
    step(); force_ack = 1'b0;
    @(negedge clock);
    chk("ar_late_ack_valid", instr_valid, 1'b0);
    chk("ar_late_ack_req", mem_req, 1'b0);

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
